// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard receiver.
package ps2_pkg;

  // Deserializer states:
  // state  | meaning
  // IDLE   | waiting for a start bit (strobe with data 0)
  // DATA   | shifting in the 8 data bits, LSB first
  // PARITY | capturing the odd-parity bit
  // STOP   | checking the stop bit and parity, then accept or reject
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } ps2_state_t;

  // Scan-code prefix bytes: extended key and key release.
  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_BRK = 8'hF0;

endpackage

// File: rtl/ps2_sync_filter.sv
// Pin conditioning for the PS/2 port: 2-FF synchronizers on both pins,
// a run-length de-glitch filter on the clock, and a matching delay on the
// data so the data sample taken at a filtered falling edge reflects the
// pin value while the device held the clock low. FILTER_LEN must be >= 2.
module ps2_sync_filter
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic reset_n,
  input  logic ps2_clk_async,
  input  logic ps2_data_async,
  output logic ps2_clk_filt,
  output logic ps2_data_aligned,
  output logic fall_stb
);

  localparam int CW = $clog2(FILTER_LEN + 1);
  localparam logic [CW-1:0] FLT_LAST = CW'(FILTER_LEN - 1);

  logic [1:0]            clk_sync;
  logic [1:0]            data_sync;
  logic [CW-1:0]         flt_cnt;
  logic [FILTER_LEN-1:0] data_dly;

  // Bring both pins into the clk domain; idle level of the bus is high.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
    end else begin
      clk_sync  <= {clk_sync[0], ps2_clk_async};
      data_sync <= {data_sync[0], ps2_data_async};
    end
  end

  // Flip the filtered clock only after FILTER_LEN consecutive differing samples; flag falls.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ps2_clk_filt <= 1'b1;
      flt_cnt      <= '0;
      fall_stb     <= 1'b0;
    end else begin
      fall_stb <= 1'b0;
      if (clk_sync[1] == ps2_clk_filt) begin
        flt_cnt <= '0;
      end else if (flt_cnt == FLT_LAST) begin
        ps2_clk_filt <= clk_sync[1];
        flt_cnt      <= '0;
        fall_stb     <= ps2_clk_filt;
      end else begin
        flt_cnt <= flt_cnt + 1'b1;
      end
    end
  end

  // Delay data by the filter length so it lines up with the filtered edge.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      data_dly <= '1;
    end else begin
      data_dly <= {data_dly[FILTER_LEN-2:0], data_sync[1]};
    end
  end

  assign ps2_data_aligned = data_dly[FILTER_LEN-1];

endmodule

// File: rtl/ps2_scan_decoder.sv
// PS/2 keyboard receiver: deserializes 11-bit device-to-host frames, holds
// the last good byte on scan_code and reports key events qualified by the
// E0 (extended) and F0 (break) prefixes that preceded them.
module ps2_scan_decoder
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 10000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ps2_clk_async,
  input  logic       ps2_data_async,
  output logic [7:0] scan_code,
  output logic       scan_valid,
  output logic       frame_err,
  output logic       key_valid,
  output logic       key_ext,
  output logic       key_break
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

  logic       ps2_clk_filt;
  logic       ps2_data_aligned;
  logic       fall_stb;
  logic       bit_stb;
  logic       tmo_hit;
  ps2_state_t state;
  logic [2:0] bit_cnt;
  logic [7:0] shift_reg;
  logic       parity_bit;
  logic       ext_pending;
  logic       brk_pending;
  logic [TW-1:0] tmo_cnt;

  ps2_sync_filter #(
    .FILTER_LEN (FILTER_LEN)
  ) u_sync_filter (
    .clk              (clk),
    .reset_n          (reset_n),
    .ps2_clk_async    (ps2_clk_async),
    .ps2_data_async   (ps2_data_async),
    .ps2_clk_filt     (ps2_clk_filt),
    .ps2_data_aligned (ps2_data_aligned),
    .fall_stb         (fall_stb)
  );

  // Bits are taken only while the filtered clock is low, i.e. on its falling edge.
  assign bit_stb = fall_stb & ~ps2_clk_filt;
  // The TIMEOUT_CYC-th consecutive strobe-less cycle inside a frame aborts it.
  assign tmo_hit = (state != IDLE) && !bit_stb && (tmo_cnt == TMO_LAST);

  // Count quiet cycles inside a frame; any strobe or return to IDLE restarts it.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      tmo_cnt <= '0;
    end else if ((state == IDLE) || bit_stb || tmo_hit) begin
      tmo_cnt <= '0;
    end else begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

  // Frame FSM with shifter, parity/stop check, prefix tracking and registered pulses.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= IDLE;
      bit_cnt     <= 3'd0;
      shift_reg   <= 8'h00;
      parity_bit  <= 1'b0;
      ext_pending <= 1'b0;
      brk_pending <= 1'b0;
      scan_code   <= 8'h00;
      scan_valid  <= 1'b0;
      frame_err   <= 1'b0;
      key_valid   <= 1'b0;
      key_ext     <= 1'b0;
      key_break   <= 1'b0;
    end else begin
      scan_valid <= 1'b0;
      frame_err  <= 1'b0;
      key_valid  <= 1'b0;
      key_ext    <= 1'b0;
      key_break  <= 1'b0;
      if (tmo_hit) begin
        // A stalled frame also invalidates any half-received prefix sequence.
        frame_err   <= 1'b1;
        state       <= IDLE;
        ext_pending <= 1'b0;
        brk_pending <= 1'b0;
      end else if (bit_stb) begin
        case (state)
          IDLE: begin
            if (!ps2_data_aligned) begin
              state   <= DATA;
              bit_cnt <= 3'd0;
            end
          end
          DATA: begin
            shift_reg <= {ps2_data_aligned, shift_reg[7:1]};
            bit_cnt   <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              state <= PARITY;
            end
          end
          PARITY: begin
            parity_bit <= ps2_data_aligned;
            state      <= STOP;
          end
          STOP: begin
            state <= IDLE;
            if (ps2_data_aligned && (^{shift_reg, parity_bit})) begin
              scan_code  <= shift_reg;
              scan_valid <= 1'b1;
              if (shift_reg == PS2_EXT) begin
                ext_pending <= 1'b1;
              end else if (shift_reg == PS2_BRK) begin
                brk_pending <= 1'b1;
              end else begin
                key_valid   <= 1'b1;
                key_ext     <= ext_pending;
                key_break   <= brk_pending;
                ext_pending <= 1'b0;
                brk_pending <= 1'b0;
              end
            end else begin
              frame_err <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ps2_scan_decoder.sv
// Self-checking bench for ps2_scan_decoder: a frame-level model predicts the
// ordered stream of accept/reject events; a negedge process matches every
// DUT pulse against it and checks the held scan_code on every cycle.
module tb_ps2_scan_decoder;

  localparam int FLT  = 8;
  localparam int TMO  = 600;
  localparam int HALF = 50;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       ps2_clk_async = 1'b1;
  logic       ps2_data_async = 1'b1;
  logic [7:0] scan_code;
  logic       scan_valid;
  logic       frame_err;
  logic       key_valid;
  logic       key_ext;
  logic       key_break;

  int n_checks = 0;
  int n_fail   = 0;
  int n_sv = 0, n_kv = 0, n_fe = 0;
  bit last_ext = 1'b0, last_brk = 1'b0;

  typedef struct {
    bit         err;
    logic [7:0] code;
    bit         kv;
    bit         ext;
    bit         brk;
  } ev_t;

  ev_t        exp_q[$];
  ev_t        cur_ev;
  logic [7:0] exp_code = 8'h00;
  bit         m_ext = 1'b0, m_brk = 1'b0;

  ps2_scan_decoder #(
    .FILTER_LEN  (FLT),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .ps2_clk_async  (ps2_clk_async),
    .ps2_data_async (ps2_data_async),
    .scan_code      (scan_code),
    .scan_valid     (scan_valid),
    .frame_err      (frame_err),
    .key_valid      (key_valid),
    .key_ext        (key_ext),
    .key_break      (key_break)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Model: what one complete frame must produce, from the protocol rules.
  task automatic model_frame(input logic [7:0] b, input bit good);
    ev_t e;
    e.err = !good; e.code = b; e.kv = 1'b0; e.ext = 1'b0; e.brk = 1'b0;
    if (good) begin
      if (b == 8'hE0) m_ext = 1'b1;
      else if (b == 8'hF0) m_brk = 1'b1;
      else begin
        e.kv = 1'b1; e.ext = m_ext; e.brk = m_brk;
        m_ext = 1'b0; m_brk = 1'b0;
      end
    end
    exp_q.push_back(e);
  endtask

  task automatic send_bits(input logic [10:0] bits, input int n, input int half);
    for (int i = 0; i < n; i++) begin
      ps2_data_async = bits[i];
      tick(half);
      ps2_clk_async = 1'b0;
      tick(half);
      ps2_clk_async = 1'b1;
    end
    ps2_data_async = 1'b1;
  endtask

  task automatic drain(input int budget);
    int k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      tick(1);
      k++;
    end
    if (exp_q.size() != 0) begin
      chk("event_wait_expired", exp_q.size(), 0);
      exp_q.delete();
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop, input int half);
    logic [10:0] f;
    logic        par;
    par = (~^b) ^ bad_par;
    f = {~bad_stop, par, b, 1'b0};
    model_frame(b, !bad_par && !bad_stop);
    send_bits(f, 11, half);
    tick(half);
    drain(300);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    exp_q.delete();
    m_ext = 1'b0;
    m_brk = 1'b0;
    ps2_clk_async = 1'b1;
    ps2_data_async = 1'b1;
    tick(5);
    reset_n = 1'b1;
    tick(1);
  endtask

  // Match every DUT pulse to the next predicted event and check the held code each cycle.
  always @(negedge clk) begin
    if (!reset_n) begin
      exp_code = 8'h00;
    end else begin
      if (scan_valid) n_sv++;
      if (frame_err) n_fe++;
      if (key_valid) begin
        n_kv++;
        last_ext = key_ext;
        last_brk = key_break;
      end
      if (scan_valid || frame_err || key_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_pulse", {29'd0, scan_valid, frame_err, key_valid}, 32'd0);
        end else begin
          cur_ev = exp_q.pop_front();
          chk("pulse_frame_err", frame_err, cur_ev.err);
          chk("pulse_scan_valid", scan_valid, !cur_ev.err);
          chk("pulse_key_valid", key_valid, cur_ev.kv);
          if (cur_ev.kv && key_valid) begin
            chk("key_ext", key_ext, cur_ev.ext);
            chk("key_break", key_break, cur_ev.brk);
          end
          if (!cur_ev.err) exp_code = cur_ev.code;
        end
      end
      chk("scan_code_held", scan_code, exp_code);
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: time limit reached, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int sv0, kv0, fe0;
    logic [7:0] b;

    do_reset();
    tick(2);
    chk("reset_scan_code", scan_code, 8'h00);
    chk("reset_pulses", {scan_valid, frame_err, key_valid, key_ext, key_break}, 5'b0);

    // Plain make code
    sv0 = n_sv; kv0 = n_kv;
    send_frame(8'h1C, 1'b0, 1'b0, HALF);
    chk("t1_code", scan_code, 8'h1C);
    chk("t1_sv_count", n_sv - sv0, 1);
    chk("t1_kv_count", n_kv - kv0, 1);
    chk("t1_quals", {last_ext, last_brk}, 2'b00);

    // Break prefix
    sv0 = n_sv; kv0 = n_kv;
    send_frame(8'hF0, 1'b0, 1'b0, HALF);
    send_frame(8'h1C, 1'b0, 1'b0, HALF);
    chk("t2_sv_count", n_sv - sv0, 2);
    chk("t2_kv_count", n_kv - kv0, 1);
    chk("t2_code", scan_code, 8'h1C);
    chk("t2_quals", {last_ext, last_brk}, 2'b01);

    // Extended break, then plain repeat
    send_frame(8'hE0, 1'b0, 1'b0, HALF);
    send_frame(8'hF0, 1'b0, 1'b0, HALF);
    send_frame(8'h75, 1'b0, 1'b0, HALF);
    chk("t3_quals", {last_ext, last_brk}, 2'b11);
    send_frame(8'h75, 1'b0, 1'b0, HALF);
    chk("t3_repeat_quals", {last_ext, last_brk}, 2'b00);

    // Parity error keeps the previous code
    send_frame(8'h16, 1'b0, 1'b0, HALF);
    sv0 = n_sv; fe0 = n_fe;
    send_frame(8'h1C, 1'b1, 1'b0, HALF);
    chk("t4_fe_count", n_fe - fe0, 1);
    chk("t4_sv_count", n_sv - sv0, 0);
    chk("t4_code", scan_code, 8'h16);

    // Bad stop bit
    fe0 = n_fe;
    send_frame(8'h29, 1'b0, 1'b1, HALF);
    chk("t4b_fe_count", n_fe - fe0, 1);
    chk("t4b_code", scan_code, 8'h16);

    // Timeout after a partial frame clears a pending break prefix
    send_frame(8'hF0, 1'b0, 1'b0, HALF);
    fe0 = n_fe;
    exp_q.push_back('{err: 1'b1, code: 8'h00, kv: 1'b0, ext: 1'b0, brk: 1'b0});
    m_ext = 1'b0; m_brk = 1'b0;
    send_bits({2'b11, 8'h5A, 1'b0}, 5, HALF);
    tick(TMO + 200);
    drain(300);
    chk("t5_fe_count", n_fe - fe0, 1);
    send_frame(8'h16, 1'b0, 1'b0, HALF);
    chk("t5_code", scan_code, 8'h16);
    chk("t5_quals", {last_ext, last_brk}, 2'b00);

    // Short clock glitch with data low must not start a frame
    sv0 = n_sv; fe0 = n_fe;
    ps2_data_async = 1'b0;
    tick(20);
    ps2_clk_async = 1'b0;
    tick(3);
    ps2_clk_async = 1'b1;
    tick(20);
    ps2_data_async = 1'b1;
    tick(TMO + 200);
    chk("t6_glitch_events", (n_sv - sv0) + (n_fe - fe0), 0);

    // Reset mid-frame drops the partial frame and the pending prefix
    send_frame(8'hE0, 1'b0, 1'b0, HALF);
    fe0 = n_fe;
    send_bits({2'b11, 8'h33, 1'b0}, 4, HALF);
    do_reset();
    tick(2);
    chk("t6_reset_code", scan_code, 8'h00);
    chk("t6_reset_no_err", n_fe - fe0, 0);
    send_frame(8'h1C, 1'b0, 1'b0, HALF);
    chk("t6_post_code", scan_code, 8'h1C);
    chk("t6_post_quals", {last_ext, last_brk}, 2'b00);

    // Randomized traffic with prefixes, corrupted frames and varied bit rates
    for (int i = 0; i < 30; i++) begin
      case ($urandom_range(0, 9))
        0: b = 8'hE0;
        1: b = 8'hF0;
        default: b = 8'($urandom_range(0, 255));
      endcase
      send_frame(b, ($urandom_range(0, 7) == 0), ($urandom_range(0, 15) == 0),
                 $urandom_range(30, 60));
      tick($urandom_range(0, 100));
    end

    tick(50);
    chk("final_queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ps2_scan_decoder.md
# ps2_scan_decoder

PS/2 keyboard receiver for the on-board CPU. It synchronizes and de-glitches the asynchronous PS/2 clock and data pins and deserializes 11-bit device-to-host frames. It exposes the last valid scan byte on a held `scan_code` register, which the CPU top forwards to the JTAG UART, and also reports key events with extended/break qualifiers.

## Interface
Parameters:
- `FILTER_LEN`, default 8: consecutive identical samples (in `clk` cycles) required to change the filtered PS/2 clock.
- `TIMEOUT_CYC`, default 10000: idle cycles (200 µs at 50 MHz) after which a partial frame is aborted.

Ports:
- `clk` input, 1 bit: system clock, 50 MHz (CLOCK_50).
- `reset_n` input, 1 bit: reset, synchronous and active-low.
- `ps2_clk_async` input, 1 bit: raw PS2_CLK pin, idle high.
- `ps2_data_async` input, 1 bit: raw PS2_DAT pin, idle high.
- `scan_code` output, 8 bits: last correctly received byte, including E0/F0 prefixes. Held until the next valid frame.
- `scan_valid` output, 1 bit: 1-cycle pulse when `scan_code` updates.
- `frame_err` output, 1 bit: 1-cycle pulse on parity error, bad stop bit, or timeout abort.
- `key_valid` output, 1 bit: 1-cycle pulse coincident with `scan_valid` for a non-prefix byte.
- `key_ext` output, 1 bit: qualifier valid with `key_valid`; set when E0 preceded the byte.
- `key_break` output, 1 bit: qualifier valid with `key_valid`; set when F0 preceded the byte.

## Operation
- Both pins pass through a 2-FF synchronizer.
- The clock path feeds a filter: the filtered clock toggles only after `FILTER_LEN` consecutive samples differ from its current value.
- The data path is delayed to match the filter, so data is sampled while PS/2 clock is low.
- A falling edge of the filtered clock is a bit strobe.
- Frame format: start bit 0, 8 data bits LSB first, odd parity, stop bit 1.
- FSM states and transitions:
  - IDLE: strobe with data 0 → DATA (bit count 0). Strobe with data 1 is ignored.
  - DATA: shift the bit in. After the 8th bit → PARITY.
  - PARITY: store the parity bit → STOP.
  - STOP: if stop=1 and popcount(data)+parity is odd → accept. Otherwise pulse `frame_err`. Either way → IDLE.
- On accept:
  - `scan_code` ← byte and `scan_valid` pulses.
  - Byte E0 sets ext_pending; byte F0 sets brk_pending. Neither pulses `key_valid`.
  - Any other byte pulses `key_valid`, with `key_ext` = ext_pending and `key_break` = brk_pending. Both pending flags then clear.
- A rejected frame leaves `scan_code` and the pending flags unchanged.
- Timeout: in any state other than IDLE, the counter increments each cycle without a strobe and resets on every strobe. Reaching `TIMEOUT_CYC` → `frame_err` pulse, FSM → IDLE, and pending flags clear.
- A glitch shorter than `FILTER_LEN` cycles on the clock pin produces no strobe.

## Timing
- Reset (sync, `reset_n`=0 at a `clk` edge):
  - `scan_code`=8'h00; all pulse outputs and `key_ext`/`key_break` = 0.
  - FSM=IDLE; synchronizers and filtered clock = 1; pending flags = 0; timeout counter = 0.
- Reset mid-frame discards the partial frame with no `frame_err`.
- Latency from the pin falling edge to the strobe = 2 (sync) + `FILTER_LEN` cycles.
- `scan_valid`, `key_valid`, and `frame_err` assert on the cycle after the stop-bit strobe, for exactly 1 cycle.
- The outputs are registered; `scan_code` updates in the same cycle `scan_valid` asserts.
- A frame arriving back-to-back with the next start bit is handled: the FSM is in IDLE one cycle after STOP.

## Structure
- Shared package `ps2_pkg`: the FSM state enum (IDLE, DATA, PARITY, STOP) and constants `PS2_EXT`=8'hE0 and `PS2_BRK`=8'hF0.
- One sub-module, `ps2_sync_filter`: the 2-FF sync plus clock filter. It outputs filtered clock, aligned data, and a falling-edge strobe.
- The FSM, shifter, parity check, timeout, and prefix tracking live in the top.

## Test plan
- Frame for 0x1C (bits 0,0,0,1,1,1,0,0,0, parity 0, stop 1) at a 12 kHz PS/2 clock. Required: `scan_code`=0x1C, one `scan_valid` pulse, `key_valid`=1 with `key_ext`=0 and `key_break`=0.
- Frames F0 (parity 1), then 0x1C. Required: two `scan_valid` pulses and `scan_code`=0x1C. `key_valid` pulses once, with `key_break`=1 and `key_ext`=0.
- Frames E0, F0, 0x75. Required: `key_valid` with `key_ext`=1 and `key_break`=1. A following 0x75 frame gives both qualifiers 0.
- 0x1C with parity bit 1 after a prior 0x16. Required: `frame_err` pulse, no `scan_valid`, and `scan_code` stays 0x16.
- 5 bits of a frame, then idle for more than 10000 cycles. Required: `frame_err` pulse. A following full 0x16 frame decodes correctly.
- A 3-cycle low glitch on `ps2_clk_async` while idle, and `reset_n` asserted mid-frame. Required: no strobe, no outputs, and `scan_code`=0x00 after reset.
